if_fetch_queue: RTL and testbench

//  Instruction-fetch back end: consumes npc from the PC generator, issues in-order

---
 rtl/if_fetch_queue.sv | 157 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch back end: issues in-order fetches, tracks in-flight pcs and
// queues returned {pc,inst} pairs for decode, flushing everything on redirect.

module if_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Upstream slot reservation must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset && !clear_i)
      assert (!(push_i && !pop_i && cnt_q == CW'(DEPTH)));
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module if_fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic        pc_stall,
  input  logic        redirect,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);
  localparam int unsigned QW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUT) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  logic [QW-1:0] qcount;
  logic [OW-1:0] pend_cnt;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [31:0]   pend_pc;
  logic [31:0]   occ;
  logic          accept, keep, pop;
  fq_entry_t     q_wdata, q_head;

  // Every in-flight request owns a queue slot, so returned data always fits.
  assign occ      = 32'(qcount) + 32'(out_q);
  assign inst_req = !reset && !redirect && (32'(out_q) < MAX_OUT) &&
                    (occ < DEPTH) && (pc_i[1:0] == 2'b00);
  assign inst_addr = pc_i;
  assign accept    = inst_req && inst_addr_ok;
  assign pc_stall  = !accept;

  assign keep = inst_data_ok && !redirect && (disc_q == '0);
  assign pop  = id_valid && id_ready && !redirect;

  always_comb begin
    out_d  = out_q + OW'(accept) - OW'(inst_data_ok);
    disc_d = disc_q;
    // Stale responses still count against outstanding until they come back.
    if (redirect)
      disc_d = out_q - OW'(inst_data_ok);
    else if (inst_data_ok && disc_q != '0)
      disc_d = disc_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (32'(pend_cnt) + 32'(disc_q) == 32'(out_q));
  end

  if_fetch_fifo #(.DEPTH(MAX_OUT), .W(32)) u_pend (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect),
    .push_i  (accept),
    .pop_i   (keep),
    .wdata_i (pc_i),
    .head_o  (pend_pc),
    .count_o (pend_cnt)
  );

  assign q_wdata = '{pc: pend_pc, inst: inst_rdata};

  if_fetch_fifo #(.DEPTH(DEPTH), .W($bits(fq_entry_t))) u_queue (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect),
    .push_i  (keep),
    .pop_i   (pop),
    .wdata_i (q_wdata),
    .head_o  (q_head),
    .count_o (qcount)
  );

  assign id_valid = (qcount != '0);
  assign id_pc    = q_head.pc;
  assign id_inst  = q_head.inst;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a bus responder and pc generator model feed
// a scoreboard of expected {pc,inst} pairs checked as decode pops them.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        reset, redirect, inst_addr_ok, inst_data_ok, id_ready;
  logic [31:0] pc_i, inst_rdata;
  logic        pc_stall, inst_req, id_valid;
  logic [31:0] inst_addr, id_pc, id_inst;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  logic [31:0] bus_q[$];
  logic [63:0] exp_q[$];
  logic        data_en;
  logic [31:0] redir_pc;
  logic [31:0] held;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_i         (pc_i),
    .pc_stall     (pc_stall),
    .redirect     (redirect),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_ready     (id_ready)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: bus drives response, outputs sampled mid-cycle, models
  // advanced after the edge.
  task automatic cyc();
    bit acc, pp;
    inst_data_ok = data_en && (bus_q.size() > 0) && !reset;
    inst_rdata   = inst_data_ok ? mem(bus_q[0]) : 32'h0;
    #1;
    acc = inst_req && inst_addr_ok;
    pp  = id_valid && id_ready && !redirect && !reset;
    chk("pc_stall", {63'd0, pc_stall}, {63'd0, !acc});
    chk("inst_addr", {32'd0, inst_addr}, {32'd0, pc_i});
    if (pp) begin
      pops++;
      if (exp_q.size() == 0) chk("pop_unexpected", 64'(exp_q.size()), 64'd1);
      else chk("pop_pc_inst", {id_pc, id_inst}, exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    if (reset) begin
      bus_q.delete();
      exp_q.delete();
    end else begin
      if (inst_data_ok) void'(bus_q.pop_front());
      if (redirect) exp_q.delete();
      if (acc) begin
        bus_q.push_back(pc_i);
        exp_q.push_back({pc_i, mem(pc_i)});
      end
      if (redirect) pc_i = redir_pc;
      else if (acc) pc_i = pc_i + 32'd4;
    end
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] npc);
    redir_pc = npc;
    redirect = 1'b1;
    cyc();
    redirect = 1'b0;
  endtask

  task automatic drain();
    inst_addr_ok = 1'b0;
    data_en = 1'b1;
    id_ready = 1'b1;
    repeat (8) cyc();
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 20 && !id_valid; k++) cyc();
    chk(tag, {63'd0, id_valid}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; inst_addr_ok = 1'b1; id_ready = 1'b1;
    data_en = 1'b0; pc_i = 32'hbfc0_0000; redir_pc = '0;
    inst_data_ok = 1'b0; inst_rdata = '0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_inst_req", {63'd0, inst_req}, 64'd0);
    chk("rst_pc_stall", {63'd0, pc_stall}, 64'd1);
    chk("rst_id_pc", {32'd0, id_pc}, 64'd0);
    chk("rst_id_inst", {32'd0, id_inst}, 64'd0);

    // 1: streaming fetch with one-cycle data latency
    reset = 1'b0; data_en = 1'b1;
    #1;
    chk("t1_req_cycle1", {63'd0, inst_req}, 64'd1);
    pops = 0;
    cyc(); cyc();
    chk("t1_id_valid", {63'd0, id_valid}, 64'd1);
    chk("t1_id_pc", {32'd0, id_pc}, 64'h0000_0000_bfc0_0000);
    chk("t1_id_inst", {32'd0, id_inst}, {32'd0, mem(32'hbfc0_0000)});
    repeat (6) cyc();
    chk("t1_pops", 64'(pops), 64'd6);

    // 2: address not accepted for three cycles
    inst_addr_ok = 1'b0;
    held = pc_i;
    repeat (3) begin
      cyc();
      chk("t2_stall", {63'd0, pc_stall}, 64'd1);
      chk("t2_addr_hold", {32'd0, inst_addr}, {32'd0, held});
    end

    // 3: queue fills to DEPTH with decode stalled, then drains in order
    drain();
    do_redirect(32'hbfc0_0000);
    id_ready = 1'b0; inst_addr_ok = 1'b1; data_en = 1'b1;
    repeat (8) cyc();
    chk("t3_req_blocked", {63'd0, inst_req}, 64'd0);
    chk("t3_next_addr", {32'd0, inst_addr}, 64'h0000_0000_bfc0_0010);
    id_ready = 1'b1; inst_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_pop_order", {32'd0, id_pc}, 64'(32'hbfc0_0000 + 32'(4 * i)));
      cyc();
    end
    chk("t3_empty", {63'd0, id_valid}, 64'd0);

    // 4: redirect with two requests in flight
    drain();
    data_en = 1'b0; inst_addr_ok = 1'b1;
    cyc(); cyc();
    chk("t4_out_limit", {63'd0, inst_req}, 64'd0);
    do_redirect(32'hbfc0_0380);
    data_en = 1'b1;
    wait_valid("t4_valid_timeout");
    chk("t4_first_pc", {32'd0, id_pc}, 64'h0000_0000_bfc0_0380);

    // 5: redirect coinciding with data_ok, one other outstanding
    drain();
    data_en = 1'b0; inst_addr_ok = 1'b1;
    cyc(); cyc();
    inst_addr_ok = 1'b0; data_en = 1'b1;
    do_redirect(32'hbfc0_0500);
    data_en = 1'b0; inst_addr_ok = 1'b1;
    #1;
    chk("t5_req_after_redir", {63'd0, inst_req}, 64'd1);
    cyc();
    inst_addr_ok = 1'b0; data_en = 1'b1;
    wait_valid("t5_valid_timeout");
    chk("t5_first_pc", {32'd0, id_pc}, 64'h0000_0000_bfc0_0500);

    // 6: misaligned pc holds until the next redirect
    drain();
    inst_addr_ok = 1'b1;
    do_redirect(32'hbfc0_0002);
    repeat (3) begin
      chk("t6_no_req", {63'd0, inst_req}, 64'd0);
      chk("t6_stall", {63'd0, pc_stall}, 64'd1);
      cyc();
    end
    do_redirect(32'hbfc0_0600);
    #1;
    chk("t6_req_resume", {63'd0, inst_req}, 64'd1);
    wait_valid("t6_valid_timeout");
    chk("t6_first_pc", {32'd0, id_pc}, 64'h0000_0000_bfc0_0600);

    drain();
    chk("end_empty", {63'd0, id_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
